// File: rtl/hazard_hold_unit.sv
// ============================================================================
// Module   : hazard_hold_unit
// Purpose  : LC-3b load-use / memory-stall hazard control with writeback hold
//            register. Optional stall counters when HAZARD_STALL_CNT_EN is set.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_hold_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  ifid_opcode_i,
  input  logic [2:0]  ifid_src1_i,
  input  logic [2:0]  ifid_src2_i,
  input  logic [2:0]  ifid_dest_i,
  input  logic        ifid_bit5_i,
  input  logic        ifid_bit11_i,
  input  logic [3:0]  idex_opcode_i,
  input  logic [2:0]  idex_dest_i,
  input  logic        idex_ld_dest_i,
  input  logic        imem_stall_i,
  input  logic        dmem_stall_i,
  input  logic        mewb_ld_dest_i,
  input  logic [2:0]  destmux_out_i,
  input  logic [15:0] regfilemux_out_i,
  output logic        stall1_o,
  output logic        bubble_o,
  output logic [19:0] hold_reg_out_o,
  output logic [15:0] ldu_cnt_o,
  output logic [15:0] mem_cnt_o
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_SHF = 4'b1101;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LDUSE    = 2'd1,
    ST_MEMSTALL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] hold_q, hold_d;

  logic        rd1_en, rd2_en;
  logic [2:0]  rd2_reg;
  logic        ex_is_load;
  logic        ldu_hazard;

  // Second read port is src2 for register-mode ALU ops, but the store-data
  // register (encoded in the dest field) for stores.
  always_comb begin
    rd1_en  = 1'b0;
    rd2_en  = 1'b0;
    rd2_reg = ifid_src2_i;
    case (ifid_opcode_i)
      OP_ADD, OP_AND: begin
        rd1_en = 1'b1;
        rd2_en = ~ifid_bit5_i;
      end
      OP_NOT, OP_SHF, OP_LDR, OP_LDB, OP_LDI, OP_JMP: begin
        rd1_en = 1'b1;
      end
      OP_JSR: begin
        rd1_en = ~ifid_bit11_i;
      end
      OP_STB, OP_STI, OP_STR: begin
        rd1_en  = 1'b1;
        rd2_en  = 1'b1;
        rd2_reg = ifid_dest_i;
      end
      default: begin
        rd1_en = 1'b0;
        rd2_en = 1'b0;
      end
    endcase
  end

  assign ex_is_load = (idex_opcode_i == OP_LDR) || (idex_opcode_i == OP_LDB) ||
                      (idex_opcode_i == OP_LDI);

  assign ldu_hazard = ex_is_load && idex_ld_dest_i &&
                      ((rd1_en && (ifid_src1_i == idex_dest_i)) ||
                       (rd2_en && (rd2_reg == idex_dest_i)));

  assign stall1_o = imem_stall_i | dmem_stall_i;
  assign bubble_o = ldu_hazard & ~stall1_o & (state_q != ST_LDUSE);

  // Memory stall always wins over a load-use bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (stall1_o)      state_d = ST_MEMSTALL;
        else if (bubble_o) state_d = ST_LDUSE;
        else               state_d = ST_RUN;
      end
      ST_LDUSE: begin
        if (stall1_o) state_d = ST_MEMSTALL;
        else          state_d = ST_RUN;
      end
      ST_MEMSTALL: begin
        if (stall1_o) state_d = ST_MEMSTALL;
        else          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Writeback value is frozen when the pipe stops and kept valid for the
  // first advancing cycle, since WB moved on while the consumer waited.
  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_RUN) begin
      if (state_d != ST_RUN) begin
        hold_d = {mewb_ld_dest_i, destmux_out_i, regfilemux_out_i};
      end else begin
        hold_d = {1'b0, hold_q[18:0]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      hold_q  <= 20'h00000;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign hold_reg_out_o = hold_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] ldu_cnt_q, ldu_cnt_d;
  logic [15:0] mem_cnt_q, mem_cnt_d;

  always_comb begin
    ldu_cnt_d = ldu_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (bubble_o && (ldu_cnt_q != 16'hFFFF)) ldu_cnt_d = ldu_cnt_q + 16'd1;
    if (stall1_o && (mem_cnt_q != 16'hFFFF)) mem_cnt_d = mem_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ldu_cnt_q <= 16'h0000;
      mem_cnt_q <= 16'h0000;
    end else begin
      ldu_cnt_q <= ldu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign ldu_cnt_o = ldu_cnt_q;
  assign mem_cnt_o = mem_cnt_q;
`else
  assign ldu_cnt_o = 16'h0000;
  assign mem_cnt_o = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_hold_unit.sv
// ============================================================================
// Module   : tb_hazard_hold_unit
// Purpose  : Directed self-checking bench for hazard_hold_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_hold_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  ifid_opcode;
  logic [2:0]  ifid_src1, ifid_src2, ifid_dest;
  logic        ifid_bit5, ifid_bit11;
  logic [3:0]  idex_opcode;
  logic [2:0]  idex_dest;
  logic        idex_ld_dest;
  logic        imem_stall, dmem_stall;
  logic        mewb_ld_dest;
  logic [2:0]  destmux_out;
  logic [15:0] regfilemux_out;
  logic        stall1, bubble;
  logic [19:0] hold_reg_out;
  logic [15:0] ldu_cnt, mem_cnt;

  int n_total = 0;
  int n_bad   = 0;

  hazard_hold_unit dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .ifid_opcode_i    (ifid_opcode),
    .ifid_src1_i      (ifid_src1),
    .ifid_src2_i      (ifid_src2),
    .ifid_dest_i      (ifid_dest),
    .ifid_bit5_i      (ifid_bit5),
    .ifid_bit11_i     (ifid_bit11),
    .idex_opcode_i    (idex_opcode),
    .idex_dest_i      (idex_dest),
    .idex_ld_dest_i   (idex_ld_dest),
    .imem_stall_i     (imem_stall),
    .dmem_stall_i     (dmem_stall),
    .mewb_ld_dest_i   (mewb_ld_dest),
    .destmux_out_i    (destmux_out),
    .regfilemux_out_i (regfilemux_out),
    .stall1_o         (stall1),
    .bubble_o         (bubble),
    .hold_reg_out_o   (hold_reg_out),
    .ldu_cnt_o        (ldu_cnt),
    .mem_cnt_o        (mem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifid_opcode = 4'h0; ifid_src1 = 3'd0; ifid_src2 = 3'd0; ifid_dest = 3'd0;
    ifid_bit5 = 1'b0; ifid_bit11 = 1'b0;
    idex_opcode = 4'h0; idex_dest = 3'd0; idex_ld_dest = 1'b0;
    imem_stall = 1'b0; dmem_stall = 1'b0;
    mewb_ld_dest = 1'b0; destmux_out = 3'd0; regfilemux_out = 16'h0000;
    #1;
  endtask

  // idex ldr r3 feeding ID add r?, r1, r3 (register mode)
  task automatic set_ldr_add_hazard();
    idex_opcode = 4'b0110; idex_dest = 3'd3; idex_ld_dest = 1'b1;
    ifid_opcode = 4'b0001; ifid_src1 = 3'd1; ifid_src2 = 3'd3; ifid_bit5 = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    n_total++; if (stall1 !== 1'b0) begin n_bad++; $display("FAIL reset_stall1 got=%b exp=0", stall1); end
    n_total++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL reset_bubble got=%b exp=0", bubble); end
    n_total++; if (hold_reg_out !== 20'h00000) begin n_bad++; $display("FAIL reset_hold got=%h exp=00000", hold_reg_out); end
    n_total++; if (ldu_cnt !== 16'h0000) begin n_bad++; $display("FAIL reset_ldu_cnt got=%h exp=0000", ldu_cnt); end
    n_total++; if (mem_cnt !== 16'h0000) begin n_bad++; $display("FAIL reset_mem_cnt got=%h exp=0000", mem_cnt); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_ldr_add_hazard();
    mewb_ld_dest = 1'b1; destmux_out = 3'd5; regfilemux_out = 16'hBEEF;
    #1;
    n_total++; if (bubble !== 1'b1) begin n_bad++; $display("FAIL lu_bubble got=%b exp=1", bubble); end
    tick();
    // LDUSE: hazard inputs still present, bubble suppressed
    n_total++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL lu_ldu_bubble got=%b exp=0", bubble); end
    n_total++; if (hold_reg_out !== 20'hDBEEF) begin n_bad++; $display("FAIL lu_capture got=%h exp=DBEEF", hold_reg_out); end
    clear_inputs();
    mewb_ld_dest = 1'b1; destmux_out = 3'd2; regfilemux_out = 16'h1234;
    tick();
    n_total++; if (hold_reg_out !== 20'hDBEEF) begin n_bad++; $display("FAIL lu_first_run got=%h exp=DBEEF", hold_reg_out); end
    tick();
    n_total++; if (hold_reg_out !== 20'h5BEEF) begin n_bad++; $display("FAIL lu_valid_clear got=%h exp=5BEEF", hold_reg_out); end
  endtask

  task automatic test_immediate();
    clear_inputs();
    set_ldr_add_hazard();
    ifid_bit5 = 1'b1;
    mewb_ld_dest = 1'b1; destmux_out = 3'd7; regfilemux_out = 16'h1111;
    #1;
    n_total++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL imm_bubble got=%b exp=0", bubble); end
    tick();
    n_total++; if (hold_reg_out !== 20'h5BEEF) begin n_bad++; $display("FAIL imm_no_capture got=%h exp=5BEEF", hold_reg_out); end
  endtask

  task automatic test_mem_stall();
    clear_inputs();
    set_ldr_add_hazard();
    mewb_ld_dest = 1'b1; destmux_out = 3'd2; regfilemux_out = 16'hCAFE;
    dmem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (stall1 !== 1'b1) begin n_bad++; $display("FAIL ms_stall1[%0d] got=%b exp=1", i, stall1); end
      n_total++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL ms_bubble[%0d] got=%b exp=0", i, bubble); end
      tick();
      mewb_ld_dest = 1'b0; destmux_out = 3'd0; regfilemux_out = 16'h0000;
      #1;
      n_total++; if (hold_reg_out !== 20'hACAFE) begin n_bad++; $display("FAIL ms_hold[%0d] got=%h exp=ACAFE", i, hold_reg_out); end
      if (i == 2) clear_inputs();
    end
    n_total++; if (stall1 !== 1'b0) begin n_bad++; $display("FAIL ms_release got=%b exp=0", stall1); end
    tick();
    n_total++; if (hold_reg_out !== 20'hACAFE) begin n_bad++; $display("FAIL ms_first_run got=%h exp=ACAFE", hold_reg_out); end
    tick();
    n_total++; if (hold_reg_out !== 20'h2CAFE) begin n_bad++; $display("FAIL ms_valid_clear got=%h exp=2CAFE", hold_reg_out); end
  endtask

  task automatic test_decode();
    clear_inputs();
    idex_opcode = 4'b0010; idex_dest = 3'd3; idex_ld_dest = 1'b1;
    ifid_opcode = 4'b0111; ifid_dest = 3'd3; ifid_src1 = 3'd6; ifid_src2 = 3'd0;
    #1;
    n_total++; if (bubble !== 1'b1) begin n_bad++; $display("FAIL str_bubble got=%b exp=1", bubble); end
    idex_ld_dest = 1'b0; #1;
    n_total++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL str_no_ld got=%b exp=0", bubble); end
    idex_ld_dest = 1'b1;
    ifid_opcode = 4'b0100; ifid_src1 = 3'd3; ifid_dest = 3'd0; ifid_bit11 = 1'b1; #1;
    n_total++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL jsr_imm got=%b exp=0", bubble); end
    ifid_bit11 = 1'b0; #1;
    n_total++; if (bubble !== 1'b1) begin n_bad++; $display("FAIL jsrr got=%b exp=1", bubble); end
    ifid_opcode = 4'b1110; #1;
    n_total++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL lea_no_read got=%b exp=0", bubble); end
    ifid_opcode = 4'b1101; idex_opcode = 4'b1010; #1;
    n_total++; if (bubble !== 1'b1) begin n_bad++; $display("FAIL ldi_shf got=%b exp=1", bubble); end
    idex_opcode = 4'b0001; #1;
    n_total++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL add_not_load got=%b exp=0", bubble); end
    idex_opcode = 4'b1010; imem_stall = 1'b1; #1;
    n_total++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL imem_prio_bubble got=%b exp=0", bubble); end
    n_total++; if (stall1 !== 1'b1) begin n_bad++; $display("FAIL imem_stall1 got=%b exp=1", stall1); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_ldu();
    clear_inputs();
    set_ldr_add_hazard();
    mewb_ld_dest = 1'b1; destmux_out = 3'd1; regfilemux_out = 16'h5555;
    tick();
    n_total++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL rst_ldu_pre got=%b exp=0", bubble); end
    do_reset();
    n_total++; if (hold_reg_out !== 20'h00000) begin n_bad++; $display("FAIL rst_ldu_hold got=%h exp=00000", hold_reg_out); end
    n_total++; if (bubble !== 1'b1) begin n_bad++; $display("FAIL rst_ldu_state got=%b exp=1", bubble); end
    clear_inputs();
  endtask

  task automatic test_counters();
    logic [15:0] exp_ldu, exp_mem;
`ifdef HAZARD_STALL_CNT_EN
    exp_ldu = 16'd2; exp_mem = 16'd4;
`else
    exp_ldu = 16'd0; exp_mem = 16'd0;
`endif
    clear_inputs();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_ldr_add_hazard();
      tick();
      tick();
      clear_inputs();
      tick();
    end
    dmem_stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    dmem_stall = 1'b0;
    tick();
    tick();
    n_total++; if (ldu_cnt !== exp_ldu) begin n_bad++; $display("FAIL cnt_ldu got=%0d exp=%0d", ldu_cnt, exp_ldu); end
    n_total++; if (mem_cnt !== exp_mem) begin n_bad++; $display("FAIL cnt_mem got=%0d exp=%0d", mem_cnt, exp_mem); end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_immediate();
    test_mem_stall();
    test_decode();
    test_reset_mid_ldu();
    test_counters();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
